// File: rtl/unidade_controle_multiciclo.sv
// Multi-cycle control unit: owns PC and IR, sequences BUSCA..ESCRITA.
// Ports: clock/reset(active-low async), instrucao, flagALU in; pc, ALU/regfile/mem controls out.
module unidade_controle_multiciclo #(
  parameter int LARGURA_PC = 32,
  parameter logic [LARGURA_PC-1:0] PC_INICIAL = '0
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [31:0]           instrucao,
  input  logic                  flagALU,
  output logic [LARGURA_PC-1:0] pc,
  output logic [5:0]            opcodeALU,
  output logic [4:0]            endRs,
  output logic [4:0]            endRt,
  output logic [4:0]            endEscrita,
  output logic [31:0]           imediatoExtendido,
  output logic                  escreveReg,
  output logic                  selDadoEscrita,
  output logic                  leMem,
  output logic                  escreveMem,
  output logic                  parado,
  output logic                  instrucaoInvalida
);

  typedef enum logic [2:0] {
    BUSCA,
    DECODIFICA,
    EXECUTA,
    MEMORIA,
    ESCRITA,
    PARADO
  } estado_t;

  localparam logic [5:0] OP_ADDI = 6'd2;

  estado_t r_estado;
  estado_t w_prox;

  logic [31:0]           r_ir;
  logic [LARGURA_PC-1:0] r_pc;
  logic                  r_invalida;

  logic [5:0]            w_op;
  logic [31:0]           w_imm;
  logic [LARGURA_PC-1:0] w_off;
  logic [LARGURA_PC-1:0] w_alvo;
  logic [LARGURA_PC-1:0] w_pc_mais1;

  logic w_tipoR;
  logic w_tipoI;
  logic w_lw;
  logic w_sw;
  logic w_j;
  logic w_halt;
  logic w_branch;
  logic w_ilegal;

  assign w_op       = r_ir[31:26];
  assign w_imm      = {{16{r_ir[15]}}, r_ir[15:0]};
  assign w_off      = LARGURA_PC'(signed'(w_imm));
  assign w_alvo     = LARGURA_PC'({6'd0, r_ir[25:0]});
  assign w_pc_mais1 = r_pc + LARGURA_PC'(1);

  // Exactly one class flag is high for any opcode.
  always_comb begin
    w_tipoR  = 1'b0;
    w_tipoI  = 1'b0;
    w_lw     = 1'b0;
    w_sw     = 1'b0;
    w_j      = 1'b0;
    w_halt   = 1'b0;
    w_branch = 1'b0;
    w_ilegal = 1'b0;
    case (w_op) inside
      6'd0, 6'd1, [6'd4:6'd11], 6'd15:
        w_tipoR = 1'b1;
      6'd2, 6'd3, [6'd12:6'd14]:
        w_tipoI = 1'b1;
      6'd16:
        w_lw = 1'b1;
      6'd17:
        w_sw = 1'b1;
      6'd18:
        w_j = 1'b1;
      6'd19:
        w_halt = 1'b1;
      [6'd22:6'd25]:
        w_branch = 1'b1;
      default:
        w_ilegal = 1'b1;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_estado <= BUSCA;
    end else begin
      r_estado <= w_prox;
    end
  end

  always_comb begin
    w_prox = r_estado;
    unique case (r_estado)
      BUSCA:
        w_prox = DECODIFICA;
      DECODIFICA: begin
        unique case (1'b1)
          w_halt:   w_prox = PARADO;
          w_j:      w_prox = BUSCA;
          w_ilegal: w_prox = BUSCA;
          default:  w_prox = EXECUTA;
        endcase
      end
      EXECUTA: begin
        unique case (1'b1)
          w_branch:    w_prox = BUSCA;
          w_lw | w_sw: w_prox = MEMORIA;
          default:     w_prox = ESCRITA;
        endcase
      end
      MEMORIA:
        w_prox = w_lw ? ESCRITA : BUSCA;
      ESCRITA:
        w_prox = BUSCA;
      PARADO:
        w_prox = PARADO;
      default:
        w_prox = BUSCA;
    endcase
  end

  // PC/IR datapath; pc already points past the branch when the offset is added.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_pc       <= PC_INICIAL;
      r_ir       <= '0;
      r_invalida <= 1'b0;
    end else begin
      case (r_estado)
        BUSCA: begin
          r_ir <= instrucao;
          r_pc <= w_pc_mais1;
        end
        DECODIFICA: begin
          if (w_j) begin
            r_pc <= w_alvo;
          end
          if (w_ilegal) begin
            r_invalida <= 1'b1;
          end
        end
        EXECUTA: begin
          if (w_branch && flagALU) begin
            r_pc <= r_pc + w_off;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Strobes decode only the state register and IR, never instrucao.
  always_comb begin
    opcodeALU      = 6'd0;
    endEscrita     = 5'd0;
    escreveReg     = 1'b0;
    selDadoEscrita = 1'b0;
    leMem          = 1'b0;
    escreveMem     = 1'b0;
    parado         = 1'b0;
    unique case (1'b1)
      w_tipoR: begin
        opcodeALU  = w_op;
        endEscrita = r_ir[15:11];
      end
      w_tipoI: begin
        opcodeALU  = w_op;
        endEscrita = r_ir[20:16];
      end
      w_lw: begin
        opcodeALU  = OP_ADDI;
        endEscrita = r_ir[20:16];
      end
      w_sw:
        opcodeALU = OP_ADDI;
      w_branch:
        opcodeALU = w_op;
      default: begin
      end
    endcase
    unique case (r_estado)
      MEMORIA: begin
        leMem      = w_lw;
        escreveMem = w_sw;
      end
      ESCRITA: begin
        escreveReg     = 1'b1;
        selDadoEscrita = w_lw;
      end
      PARADO:
        parado = 1'b1;
      default: begin
      end
    endcase
  end

  assign pc                = r_pc;
  assign endRs             = r_ir[25:21];
  assign endRt             = r_ir[20:16];
  assign imediatoExtendido = w_imm;
  assign instrucaoInvalida = r_invalida;

endmodule

// File: tb/tb_unidade_controle_multiciclo.sv
// Bench for unidade_controle_multiciclo: strobe scoreboard plus directed pc/decode checks.
// Small program in an instruction ROM exercises ALU, lw/sw, j, branch, illegal, halt, reset.
module tb_unidade_controle_multiciclo;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] instrucao;
  logic        flagALU = 1'b1;
  logic [31:0] pc;
  logic [5:0]  opcodeALU;
  logic [4:0]  endRs;
  logic [4:0]  endRt;
  logic [4:0]  endEscrita;
  logic [31:0] imediatoExtendido;
  logic        escreveReg;
  logic        selDadoEscrita;
  logic        leMem;
  logic        escreveMem;
  logic        parado;
  logic        instrucaoInvalida;

  unidade_controle_multiciclo dut (
    .clock(clock),
    .reset(reset),
    .instrucao(instrucao),
    .flagALU(flagALU),
    .pc(pc),
    .opcodeALU(opcodeALU),
    .endRs(endRs),
    .endRt(endRt),
    .endEscrita(endEscrita),
    .imediatoExtendido(imediatoExtendido),
    .escreveReg(escreveReg),
    .selDadoEscrita(selDadoEscrita),
    .leMem(leMem),
    .escreveMem(escreveMem),
    .parado(parado),
    .instrucaoInvalida(instrucaoInvalida)
  );

  always #5 clock = ~clock;

  int ciclo = 0;
  always @(posedge clock) ciclo <= ciclo + 1;

  logic [31:0] imem [0:15];
  assign instrucao = imem[pc[3:0]];

  typedef struct {
    int         tipo;
    int         ciclo;
    logic [4:0] ender;
    logic       sel;
  } ev_t;

  ev_t fila[$];
  int  errors = 0;
  int  checks = 0;

  task automatic chk(string nome, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nome, got, exp);
    end
  endtask

  task automatic push(int tipo, int c, logic [4:0] e, logic s);
    ev_t ev;
    ev.tipo  = tipo;
    ev.ciclo = c;
    ev.ender = e;
    ev.sel   = s;
    fila.push_back(ev);
  endtask

  task automatic ate(int n);
    int guarda = 0;
    while (ciclo != n && guarda < 1000) begin
      @(negedge clock);
      guarda++;
    end
    if (guarda >= 1000) chk("timeout", 32'(ciclo), 32'(n));
  endtask

  // Monitor: one scoreboard entry per strobe cycle (0 write, 1 read, 2 store).
  always @(negedge clock) begin
    if (reset && (escreveReg || leMem || escreveMem)) begin
      int tipo;
      ev_t ev;
      tipo = escreveReg ? 0 : (leMem ? 1 : 2);
      chk("strobe_exclusivo",
          32'(escreveReg) + 32'(leMem) + 32'(escreveMem), 32'd1);
      if (fila.size() == 0) begin
        chk("strobe_inesperado", 32'(tipo), 32'hFFFF_FFFF);
      end else begin
        ev = fila.pop_front();
        chk("strobe_tipo", 32'(tipo), 32'(ev.tipo));
        chk("strobe_ciclo", 32'(ciclo), 32'(ev.ciclo));
        if (ev.tipo == 0) begin
          chk("escrita_end", 32'(endEscrita), 32'(ev.ender));
          chk("escrita_sel", 32'(selDadoEscrita), 32'(ev.sel));
        end
      end
    end
  end

  initial begin
    int r;
    int r2;
    int r3;
    for (int i = 0; i < 16; i++) imem[i] = 32'h0;
    imem[0]  = {6'd0, 5'd1, 5'd2, 5'd3, 11'd0};
    imem[1]  = {6'd2, 5'd4, 5'd5, 16'hFFFF};
    imem[2]  = {6'd16, 5'd6, 5'd7, 16'd4};
    imem[3]  = {6'd17, 5'd8, 5'd9, 16'd8};
    imem[4]  = {6'd18, 26'd10};
    imem[8]  = {6'd30, 26'd0};
    imem[9]  = {6'd18, 26'd10};
    imem[10] = {6'd22, 5'd1, 5'd2, 16'hFFFD};
    imem[11] = {6'd19, 26'd0};

    repeat (3) @(negedge clock);
    chk("rst_pc", pc, 32'd0);
    chk("rst_strobes", {29'd0, escreveReg, leMem, escreveMem}, 32'd0);
    chk("rst_parado", 32'(parado), 32'd0);
    chk("rst_invalida", 32'(instrucaoInvalida), 32'd0);

    reset = 1'b1;
    r = ciclo;
    push(0, r + 3, 5'd3, 1'b0);
    push(0, r + 7, 5'd5, 1'b0);
    push(1, r + 11, 5'd0, 1'b0);
    push(0, r + 12, 5'd7, 1'b1);
    push(2, r + 16, 5'd0, 1'b0);

    ate(r + 2);
    chk("add_op", 32'(opcodeALU), 32'd0);
    chk("add_end", 32'(endEscrita), 32'd3);
    chk("add_rs_rt", {22'd0, endRs, endRt}, {22'd0, 5'd1, 5'd2});
    ate(r + 4);
    chk("add_pc", pc, 32'd1);
    ate(r + 5);
    chk("addi_imm", imediatoExtendido, 32'hFFFF_FFFF);
    chk("addi_end", 32'(endEscrita), 32'd5);
    ate(r + 6);
    chk("addi_op", 32'(opcodeALU), 32'd2);
    ate(r + 10);
    chk("lw_op", 32'(opcodeALU), 32'd2);
    ate(r + 15);
    chk("sw_op", 32'(opcodeALU), 32'd2);
    ate(r + 19);
    chk("j_pc", pc, 32'd10);
    ate(r + 21);
    chk("beq_op", 32'(opcodeALU), 32'd22);
    ate(r + 22);
    chk("beq_taken_pc", pc, 32'd8);
    flagALU = 1'b0;
    ate(r + 23);
    chk("ilegal_antes", 32'(instrucaoInvalida), 32'd0);
    ate(r + 24);
    chk("ilegal_flag", 32'(instrucaoInvalida), 32'd1);
    chk("ilegal_pc", pc, 32'd9);
    ate(r + 26);
    chk("j2_pc", pc, 32'd10);
    ate(r + 29);
    chk("beq_not_pc", pc, 32'd11);
    ate(r + 31);
    chk("halt_parado", 32'(parado), 32'd1);
    chk("halt_pc", pc, 32'd12);
    ate(r + 51);
    chk("halt_20_parado", 32'(parado), 32'd1);
    chk("halt_20_pc", pc, 32'd12);
    chk("fila_prog", 32'(fila.size()), 32'd0);

    reset = 1'b0;
    @(negedge clock);
    chk("rst2_parado", 32'(parado), 32'd0);
    chk("rst2_invalida", 32'(instrucaoInvalida), 32'd0);
    reset = 1'b1;
    r2 = ciclo;
    ate(r2 + 2);
    @(posedge clock);
    #1;
    chk("escrita_ativa", 32'(escreveReg), 32'd1);
    reset = 1'b0;
    #1;
    chk("rst_async_pc", pc, 32'd0);
    chk("rst_async_wr", 32'(escreveReg), 32'd0);
    @(negedge clock);
    reset = 1'b1;
    r3 = ciclo;
    push(0, r3 + 3, 5'd3, 1'b0);
    ate(r3 + 4);
    chk("retoma_pc", pc, 32'd1);
    reset = 1'b0;
    @(negedge clock);
    chk("fila_final", 32'(fila.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
